// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator-side controller between the CPU control unit and the
//   word-addressed async_mem data memory. It accepts byte/half/word loads and
//   stores over a valid/ready request channel and drives the memory. The
//   memory only writes whole words, so byte and half stores use a
//   read-modify-write. Load results are lane-extracted and sign- or
//   zero-extended, then returned over a valid/ready response channel.
//
// Parameters
//   WAIT_CYCLES  cycles mem_read is held before mem_rdata is sampled (>= 1)
//
// Ports
//   clk, reset                      clock; synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_signed    store flag, size (00 B, 01 H, 10 W), extend
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_err            load result, misaligned/reserved-size flag
//   mem_read, mem_write             memory strobes (gated off during reset)
//   mem_addr, mem_wdata, mem_rdata  word address, write word, read word
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_last;
    logic               req_error;

    // Request attributes latched on acceptance; needed after req_* go don't-care.
    logic [1:0]         size_q;
    logic               signed_q;
    logic [1:0]         offset_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic        sext
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = word[{offset[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: load_extract = {{24{sext & b[7]}}, b};
            SIZE_HALF: load_extract = {{16{sext & h[15]}}, h};
            default:   load_extract = word;
        endcase
    endfunction

    // Overwrite only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  offset
    );
        store_merge = old_word;
        case (size)
            SIZE_BYTE: store_merge[{offset, 3'b000} +: 8]     = data[7:0];
            SIZE_HALF: store_merge[{offset[1], 4'b0000} +: 16] = data[15:0];
            default:   store_merge = data;
        endcase
    endfunction

    assign req_error = (req_size == 2'b11)
                    || ((req_size == SIZE_HALF) && req_addr[0])
                    || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

    assign cnt_last = (cnt == CNT_W'(WAIT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_error)               state_next = RESP;
                    else if (!req_we)            state_next = READ;
                    else if (req_size == SIZE_WORD) state_next = WRITE;
                    else                         state_next = RMW_RD;
                end
            end
            READ:    if (cnt_last)   state_next = RESP;
            RMW_RD:  if (cnt_last)   state_next = WRITE;
            WRITE:                   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Output logic. Memory strobes are masked by reset so a reset edge
    // can never commit a write.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_read   = ((state == READ) || (state == RMW_RD)) && !reset;
        mem_write  = (state == WRITE) && !reset;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

    // Datapath registers and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            offset_q     <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        size_q       <= req_size;
                        signed_q     <= req_signed;
                        offset_q     <= req_addr[1:0];
                        mem_addr_q   <= {req_addr[31:2], 2'b00};
                        // Holds the right-aligned store data until the
                        // read-modify-write merge replaces it.
                        mem_wdata_q  <= req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_error;
                    end
                end
                READ: begin
                    if (cnt_last) begin
                        cnt          <= '0;
                        resp_rdata_q <= load_extract(mem_rdata, size_q, offset_q, signed_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RMW_RD: begin
                    if (cnt_last) begin
                        cnt         <= '0;
                        mem_wdata_q <= store_merge(mem_rdata, mem_wdata_q, size_q, offset_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl (WAIT_CYCLES = 1) attached to a small
//   behavioural async_mem: combinational read, write on posedge while
//   mem_write is high. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle, then run until resp_valid (bounded),
    // counting memory strobes and capturing the last write address/data.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int rd, output int wr,
                         output logic [31:0] wa, output logic [31:0] wd);
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
        lat = 1; rd = 0; wr = 0; wa = '0; wd = '0;
        while (!resp_valid && lat < 20) begin
            if (mem_read) rd++;
            if (mem_write) begin
                wr++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            tick();
            lat++;
        end
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("idle_after_resp", {30'd0, req_ready, resp_valid}, 32'h2);
    endtask

    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input int exp_rd, input int exp_wr,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       output logic [31:0] wa, output logic [31:0] wd);
        int lat, rd, wr;
        issue(we, size, sgn, addr, wdata, lat, rd, wr, wa, wd);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_reads"},   32'(rd),  32'(exp_rd));
        check({tag, "_writes"},  32'(wr),  32'(exp_wr));
        check({tag, "_rdata"},   resp_rdata, exp_rdata);
        check({tag, "_err"},     32'(resp_err), 32'(exp_err));
        complete();
    endtask

    initial begin
        logic [31:0] wa, wd;
        int          lat, rd, wr;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr",   mem_addr,   32'd0);
        check("rst_mem_wdata",  mem_wdata,  32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err",   32'(resp_err), 32'd0);

        // 1: word store then word load
        txn("st_w40", 1'b1, W, 1'b0, 32'h40, 32'hDEADBEEF, 2, 0, 1, 32'h0, 1'b0, wa, wd);
        check("st_w40_addr",  wa, 32'h40);
        check("st_w40_wdata", wd, 32'hDEADBEEF);
        txn("ld_w40", 1'b0, W, 1'b0, 32'h40, 32'h0, 2, 1, 0, 32'hDEADBEEF, 1'b0, wa, wd);

        // 2: byte read-modify-write store
        txn("pre_100", 1'b1, W, 1'b0, 32'h100, 32'h11223344, 2, 0, 1, 32'h0, 1'b0, wa, wd);
        txn("st_b102", 1'b1, B, 1'b0, 32'h102, 32'h000000AA, 3, 1, 1, 32'h0, 1'b0, wa, wd);
        check("st_b102_addr",  wa, 32'h100);
        check("st_b102_wdata", wd, 32'h11AA3344);
        txn("ld_w100", 1'b0, W, 1'b0, 32'h100, 32'h0, 2, 1, 0, 32'h11AA3344, 1'b0, wa, wd);
        txn("st_h102", 1'b1, H, 1'b0, 32'h102, 32'h0000BEEF, 3, 1, 1, 32'h0, 1'b0, wa, wd);
        check("st_h102_wdata", wd, 32'hBEEF3344);

        // 3: lane extraction and extension
        txn("pre_80",   1'b1, W, 1'b0, 32'h80, 32'h000080F0, 2, 0, 1, 32'h0, 1'b0, wa, wd);
        txn("ld_bs80",  1'b0, B, 1'b1, 32'h80, 32'h0, 2, 1, 0, 32'hFFFFFFF0, 1'b0, wa, wd);
        txn("ld_bu80",  1'b0, B, 1'b0, 32'h80, 32'h0, 2, 1, 0, 32'h000000F0, 1'b0, wa, wd);
        txn("ld_hs80",  1'b0, H, 1'b1, 32'h80, 32'h0, 2, 1, 0, 32'hFFFF80F0, 1'b0, wa, wd);
        txn("ld_bs81",  1'b0, B, 1'b1, 32'h81, 32'h0, 2, 1, 0, 32'hFFFFFF80, 1'b0, wa, wd);
        txn("ld_hu82",  1'b0, H, 1'b0, 32'h82, 32'h0, 2, 1, 0, 32'h00000000, 1'b0, wa, wd);

        // 4: misaligned and reserved-size requests
        txn("err_ld_w06", 1'b0, W, 1'b0, 32'h06, 32'h0, 1, 0, 0, 32'h0, 1'b1, wa, wd);
        txn("err_st_h03", 1'b1, H, 1'b0, 32'h03, 32'h1234, 1, 0, 0, 32'h0, 1'b1, wa, wd);
        txn("err_rsv",    1'b0, R, 1'b0, 32'h80, 32'h0, 1, 0, 0, 32'h0, 1'b1, wa, wd);

        // 5: response back-pressure; a store presented meanwhile must be ignored
        issue(1'b0, W, 1'b0, 32'h80, 32'h0, lat, rd, wr, wa, wd);
        check("hold_latency", 32'(lat), 32'd2);
        req_valid = 1'b1; req_we = 1'b1; req_size = W; req_addr = 32'h80; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_resp_rdata", resp_rdata, 32'h000080F0);
            check("hold_req_ready",  32'(req_ready), 32'd0);
            check("hold_no_write",   32'(mem_write), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        complete();
        txn("ld_w80", 1'b0, W, 1'b0, 32'h80, 32'h0, 2, 1, 0, 32'h000080F0, 1'b0, wa, wd);

        // 6: reset during the WRITE of a byte store
        txn("pre_c0", 1'b1, W, 1'b0, 32'hC0, 32'hCAFEBABE, 2, 0, 1, 32'h0, 1'b0, wa, wd);
        check("rr_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = B; req_signed = 1'b0;
        req_addr = 32'hC1; req_wdata = 32'h55;
        tick();
        req_valid = 1'b0;
        check("rr_rmw_read", 32'(mem_read), 32'd1);
        tick();
        check("rr_write",       32'(mem_write), 32'd1);
        check("rr_write_wdata", mem_wdata, 32'hCAFE55BE);
        reset = 1'b1;
        #1;
        check("rr_write_gated", 32'(mem_write), 32'd0);
        tick();
        reset = 1'b0;
        check("rr_mem_kept",    mem[8'h30], 32'hCAFEBABE);
        check("rr_req_ready",   32'(req_ready),  32'd1);
        check("rr_resp_valid",  32'(resp_valid), 32'd0);
        check("rr_mem_strobe",  {30'd0, mem_read, mem_write}, 32'd0);
        check("rr_mem_addr",    mem_addr,   32'd0);
        check("rr_mem_wdata",   mem_wdata,  32'd0);
        check("rr_resp_rdata",  resp_rdata, 32'd0);
        check("rr_resp_err",    32'(resp_err), 32'd0);
        txn("ld_wc0", 1'b0, W, 1'b0, 32'hC0, 32'h0, 2, 1, 0, 32'hCAFEBABE, 1'b0, wa, wd);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
